qdr_port_arbiter: RTL and testbench
===================================

// Module: qdr_port_arbiter
// PURPOSE
//  Shares one QDRII controller user port (one qdrii_top instance) between NUM_REQ requesters.
//  Write and read channels are arbitrated independently with round-robin.
//  BL4 writes are sequenced as two data beats.
//  Read returns are steered back to the issuing requester through an in-order tag FIFO.
//  Sits between the user logic and the user_* port of one memory chip controller.
// PARAMETERS
//  NUM_REQ        2    number of requesters (2..4)
//  MEM_ADDR_WIDTH 19   QDR word address width
//  MEM_WIDTH      36   QDR data width; one user beat = 2*MEM_WIDTH
//  MEM_BW_WIDTH   4    byte-write bits per QDR word
//  TAG_DEPTH      16   outstanding-read tag FIFO depth (power of 2)
// PORTS
//  memclk        in   1                    clock
//  memreset      in   1                    synchronous, active-high reset
//  wr_req        in   NUM_REQ              write request, held until granted
//  wr_addr       in   NUM_REQ*AW           write address per requester
//  wr_data       in   NUM_REQ*4*MEM_WIDTH  {beat1,beat0} write data per requester
//  wr_bw_n       in   NUM_REQ*4*MEM_BW     {beat1,beat0} byte enables, active low
//  wr_gnt        out  NUM_REQ              1-cycle write grant; request is consumed
//  rd_req        in   NUM_REQ              read request, held until granted
//  rd_addr       in   NUM_REQ*AW           read address per requester
//  rd_gnt        out  NUM_REQ              1-cycle read grant
//  rd_data       out  2*MEM_WIDTH          shared read-return bus
//  rd_valid      out  NUM_REQ              one-hot; qualifies rd_data for the owner
//  user_*        out/in                    to/from qdrii_top: ad_w_n, d_w_n, ad_wr, bw_n, dw,
//                                          r_n, ad_rd / wr_full, rd_full, qr, qr_valid
//  cal_done      in   1                    controller calibration complete
//  tag_overflow  out  1                    sticky: qr_valid arrived with the tag FIFO empty
// BEHAVIOUR
//  Reset values: all gnt/valid = 0; user_ad_w_n, user_d_w_n, user_r_n = 1.
//    Buses = 0; RR pointers = 0; tag FIFO empty; tag_overflow = 0; state WAIT_CAL.
//  FSM: WAIT_CAL -> RUN when cal_done = 1. RUN -> WAIT_CAL when cal_done = 0.
//    No new grants in WAIT_CAL. Outstanding reads still drain and route.
//  Write channel FSM: W_IDLE / W_BEAT1.
//    W_IDLE, wr_req != 0, !user_wr_full, RUN: grant the RR winner (wr_gnt at t).
//      At t+1 drive ad_w_n = 0, d_w_n = 0, ad_wr, beat0; go to W_BEAT1.
//    W_BEAT1: at t+2 drive d_w_n = 0 with registered beat1; return to W_IDLE.
//    Maximum rate: one write every 2 cycles.
//    RR pointer advances to winner+1 after each grant.
//  Read channel: grant at most one per cycle when all hold:
//    rd_req != 0, !user_rd_full, tag FIFO not full, RUN.
//    r_n = 0 with ad_rd at t+1; push the winner index into the tag FIFO at t.
//    RR pointer advances to winner+1 after each grant.
//  Return path:
//    Each read yields 2 consecutive qr_valid beats.
//    rd_data <= user_qr; rd_valid[head] <= 1, one-cycle register latency.
//    Pop the tag after the 2nd beat; a beat-toggle flop tracks the beat.
//  Simultaneous push and pop when full: the pop frees the slot.
//    Full is evaluated on the registered count, so no grant is issued while count == TAG_DEPTH.
//  qr_valid with the FIFO empty: rd_valid stays 0, tag_overflow <= 1, no pop.
//  Reset mid-operation: everything returns to reset values in the next cycle.
//    In-flight beats are discarded.
//  A request dropped before grant is simply not served. Grant is never issued to req=0.
// CONFIGURATION
//  QDR_ARB_STATS_EN defined:
//    adds outputs wr_grant_cnt[31:0] and rd_grant_cnt[31:0].
//    Totals of grants; saturate at 32'hFFFFFFFF; cleared by memreset.
//  Not defined: ports and counters absent; arbitration behaviour is identical.
// TESTING
//  1. cal_done = 0, all req = 1 for 50 cycles -> no gnt. cal_done -> 1: first wr_gnt = 2'b01 next cycle.
//  2. wr_req = 2'b11 held -> wr_gnt alternates 01,10,01 on every 2nd cycle.
//     user_d_w_n low 2 consecutive cycles per grant; beat order beat0 then beat1.
//  3. rd_req = 2'b11 with addr 0x10/0x20; model returns 2 beats each after 8 cycles.
//     -> rd_valid = 01 x2, then 10 x2, each with matching data.
//  4. 16 reads granted with no returns -> the 17th is blocked.
//     One return completes -> the next grant arrives within 1 cycle of the pop.
//  5. Spurious qr_valid with no outstanding read -> tag_overflow = 1 and held; rd_valid = 0.
//  6. user_wr_full = 1 -> no wr_gnt.
//     memreset mid W_BEAT1 -> user_d_w_n = 1 the next cycle.
//     With QDR_ARB_STATS_EN: counters = 0 after reset.

Source files
------------

// File: rtl/qdr_port_arbiter_if.sv
// rtl/qdr_port_arbiter_if.sv - requester-side and QDRII user-port signals of qdr_port_arbiter
interface qdr_port_arbiter_if #(
    parameter int NUM_REQ        = 2,
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int MEM_WIDTH      = 36,
    parameter int MEM_BW_WIDTH   = 4
);
    // requester side
    logic [NUM_REQ-1:0]                  wr_req;
    logic [NUM_REQ*MEM_ADDR_WIDTH-1:0]   wr_addr;
    logic [NUM_REQ*4*MEM_WIDTH-1:0]      wr_data;
    logic [NUM_REQ*4*MEM_BW_WIDTH-1:0]   wr_bw_n;
    logic [NUM_REQ-1:0]                  wr_gnt;
    logic [NUM_REQ-1:0]                  rd_req;
    logic [NUM_REQ*MEM_ADDR_WIDTH-1:0]   rd_addr;
    logic [NUM_REQ-1:0]                  rd_gnt;
    logic [2*MEM_WIDTH-1:0]              rd_data;
    logic [NUM_REQ-1:0]                  rd_valid;
    // controller user port
    logic                                user_ad_w_n;
    logic                                user_d_w_n;
    logic [MEM_ADDR_WIDTH-1:0]           user_ad_wr;
    logic [2*MEM_BW_WIDTH-1:0]           user_bw_n;
    logic [2*MEM_WIDTH-1:0]              user_dw;
    logic                                user_r_n;
    logic [MEM_ADDR_WIDTH-1:0]           user_ad_rd;
    logic                                user_wr_full;
    logic                                user_rd_full;
    logic [2*MEM_WIDTH-1:0]              user_qr;
    logic                                user_qr_valid;

    modport slave (
        input  wr_req, wr_addr, wr_data, wr_bw_n, rd_req, rd_addr,
               user_wr_full, user_rd_full, user_qr, user_qr_valid,
        output wr_gnt, rd_gnt, rd_data, rd_valid,
               user_ad_w_n, user_d_w_n, user_ad_wr, user_bw_n, user_dw, user_r_n, user_ad_rd
    );

    modport master (
        output wr_req, wr_addr, wr_data, wr_bw_n, rd_req, rd_addr,
               user_wr_full, user_rd_full, user_qr, user_qr_valid,
        input  wr_gnt, rd_gnt, rd_data, rd_valid,
               user_ad_w_n, user_d_w_n, user_ad_wr, user_bw_n, user_dw, user_r_n, user_ad_rd
    );
endinterface

// File: rtl/qdr_port_arbiter.sv
// rtl/qdr_port_arbiter.sv - round-robin sharing of one QDRII user port; QDR_ARB_STATS_EN adds grant counters
module qdr_port_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int MEM_WIDTH      = 36,
    parameter int MEM_BW_WIDTH   = 4,
    parameter int TAG_DEPTH      = 16
) (
    input  logic                 memclk,
    input  logic                 memreset,
    input  logic                 cal_done,
    qdr_port_arbiter_if.slave    bus,
`ifdef QDR_ARB_STATS_EN
    output logic [31:0]          wr_grant_cnt,
    output logic [31:0]          rd_grant_cnt,
`endif
    output logic                 tag_overflow
);
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW  = MEM_ADDR_WIDTH;
    localparam int DW  = 2 * MEM_WIDTH;
    localparam int BWW = 2 * MEM_BW_WIDTH;
    localparam int TPW = $clog2(TAG_DEPTH);
    localparam int CW  = TPW + 1;

    typedef enum logic {WAIT_CAL, RUN}     run_state_t;
    typedef enum logic {W_IDLE, W_BEAT1}   wr_state_t;

    run_state_t          run_q, run_d;
    wr_state_t           wr_state_q, wr_state_d;
    logic [IW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_win, rd_win;
    logic                ad_w_n_q, ad_w_n_d, d_w_n_q, d_w_n_d, r_n_q, r_n_d;
    logic [AW-1:0]       ad_wr_q, ad_wr_d, ad_rd_q, ad_rd_d;
    logic [DW-1:0]       dw_q, dw_d, beat1_q, beat1_d, rd_data_q, rd_data_d;
    logic [BWW-1:0]      bw_n_q, bw_n_d, bw1_q, bw1_d;
    logic [NUM_REQ-1:0]  wr_gnt, rd_gnt, rd_valid_q, rd_valid_d;
    logic                wr_fire, rd_fire, push, pop, ret_hit, tag_full, tag_empty;
    logic                beat_q, beat_d, ovf_q, ovf_d;
    logic [TPW-1:0]      tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
    logic [CW-1:0]       tag_cnt_q, tag_cnt_d;
    logic [IW-1:0]       tag_mem [TAG_DEPTH];
    logic [IW-1:0]       head;

    // first requesting index at or after ptr, wrapping
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [IW-1:0] ptr);
        logic [IW-1:0] win;
        int            idx;
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) win = IW'(idx);
        end
        return win;
    endfunction

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] win);
        return IW'((int'(win) + 1) % NUM_REQ);
    endfunction

    assign tag_full  = (tag_cnt_q == CW'(TAG_DEPTH));
    assign tag_empty = (tag_cnt_q == '0);
    assign head      = tag_mem[tag_rp_q];
    assign wr_win    = rr_pick(bus.wr_req, wr_ptr_q);
    assign rd_win    = rr_pick(bus.rd_req, rd_ptr_q);
    assign wr_fire   = !memreset && (run_q == RUN) && (wr_state_q == W_IDLE) && (|bus.wr_req) && !bus.user_wr_full;
    assign rd_fire   = !memreset && (run_q == RUN) && (|bus.rd_req) && !bus.user_rd_full && !tag_full;
    assign ret_hit   = bus.user_qr_valid && !tag_empty;
    assign push      = rd_fire;
    assign pop       = ret_hit && beat_q;

    // calibration gate: grants only while the controller reports calibrated
    always_comb begin
        run_d = run_q;
        case (run_q)
            WAIT_CAL: if (cal_done)  run_d = RUN;
            RUN:      if (!cal_done) run_d = WAIT_CAL;
            default:                 run_d = WAIT_CAL;
        endcase
    end

    // write channel: grant, then beat0 with address, then beat1
    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_gnt     = '0;
        ad_w_n_d   = 1'b1;
        d_w_n_d    = 1'b1;
        ad_wr_d    = ad_wr_q;
        dw_d       = dw_q;
        bw_n_d     = bw_n_q;
        beat1_d    = beat1_q;
        bw1_d      = bw1_q;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_fire) begin
                    wr_gnt[wr_win] = 1'b1;
                    wr_ptr_d   = rr_next(wr_win);
                    ad_w_n_d   = 1'b0;
                    d_w_n_d    = 1'b0;
                    ad_wr_d    = bus.wr_addr[int'(wr_win) * AW +: AW];
                    dw_d       = bus.wr_data[int'(wr_win) * 2 * DW +: DW];
                    beat1_d    = bus.wr_data[int'(wr_win) * 2 * DW + DW +: DW];
                    bw_n_d     = bus.wr_bw_n[int'(wr_win) * 2 * BWW +: BWW];
                    bw1_d      = bus.wr_bw_n[int'(wr_win) * 2 * BWW + BWW +: BWW];
                    wr_state_d = W_BEAT1;
                end
            end
            W_BEAT1: begin
                d_w_n_d    = 1'b0;
                dw_d       = beat1_q;
                bw_n_d     = bw1_q;
                wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // read issue, tag FIFO bookkeeping and return steering
    always_comb begin
        rd_gnt     = '0;
        rd_ptr_d   = rd_ptr_q;
        r_n_d      = 1'b1;
        ad_rd_d    = ad_rd_q;
        tag_wp_d   = tag_wp_q;
        tag_rp_d   = tag_rp_q;
        tag_cnt_d  = tag_cnt_q;
        beat_d     = beat_q;
        ovf_d      = ovf_q;
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        if (rd_fire) begin
            rd_gnt[rd_win] = 1'b1;
            rd_ptr_d = rr_next(rd_win);
            r_n_d    = 1'b0;
            ad_rd_d  = bus.rd_addr[int'(rd_win) * AW +: AW];
            tag_wp_d = tag_wp_q + TPW'(1);
        end
        if (bus.user_qr_valid) begin
            rd_data_d = bus.user_qr;
            if (tag_empty) begin
                ovf_d = 1'b1;
            end else begin
                rd_valid_d[head] = 1'b1;
                beat_d = !beat_q;
            end
        end
        if (pop) tag_rp_d = tag_rp_q + TPW'(1);
        case ({push, pop})
            2'b10:   tag_cnt_d = tag_cnt_q + CW'(1);
            2'b01:   tag_cnt_d = tag_cnt_q - CW'(1);
            default: tag_cnt_d = tag_cnt_q;
        endcase
    end

    // state and output registers
    always_ff @(posedge memclk) begin
        if (memreset) begin
            run_q      <= WAIT_CAL;
            wr_state_q <= W_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ad_w_n_q   <= 1'b1;
            d_w_n_q    <= 1'b1;
            r_n_q      <= 1'b1;
            ad_wr_q    <= '0;
            ad_rd_q    <= '0;
            dw_q       <= '0;
            beat1_q    <= '0;
            bw_n_q     <= '0;
            bw1_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            tag_wp_q   <= '0;
            tag_rp_q   <= '0;
            tag_cnt_q  <= '0;
            beat_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            run_q      <= run_d;
            wr_state_q <= wr_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ad_w_n_q   <= ad_w_n_d;
            d_w_n_q    <= d_w_n_d;
            r_n_q      <= r_n_d;
            ad_wr_q    <= ad_wr_d;
            ad_rd_q    <= ad_rd_d;
            dw_q       <= dw_d;
            beat1_q    <= beat1_d;
            bw_n_q     <= bw_n_d;
            bw1_q      <= bw1_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            tag_wp_q   <= tag_wp_d;
            tag_rp_q   <= tag_rp_d;
            tag_cnt_q  <= tag_cnt_d;
            beat_q     <= beat_d;
            ovf_q      <= ovf_d;
        end
    end

    // tag storage: requester index of each outstanding read, in issue order
    always_ff @(posedge memclk) begin
        if (push) tag_mem[tag_wp_q] <= rd_win;
    end

`ifdef QDR_ARB_STATS_EN
    logic [31:0] wr_cnt_q, rd_cnt_q;

    // saturating grant totals
    always_ff @(posedge memclk) begin
        if (memreset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if ((|wr_gnt) && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 32'd1;
            if ((|rd_gnt) && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign wr_grant_cnt = wr_cnt_q;
    assign rd_grant_cnt = rd_cnt_q;
`endif

    assign bus.wr_gnt      = wr_gnt;
    assign bus.rd_gnt      = rd_gnt;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.user_ad_w_n = ad_w_n_q;
    assign bus.user_d_w_n  = d_w_n_q;
    assign bus.user_ad_wr  = ad_wr_q;
    assign bus.user_bw_n   = bw_n_q;
    assign bus.user_dw     = dw_q;
    assign bus.user_r_n    = r_n_q;
    assign bus.user_ad_rd  = ad_rd_q;
    assign tag_overflow    = ovf_q;
endmodule

// File: tb/tb_qdr_port_arbiter.sv
// tb/tb_qdr_port_arbiter.sv - directed vector bench for qdr_port_arbiter
module tb_qdr_port_arbiter;
    localparam logic [18:0] A0  = 19'h100;
    localparam logic [18:0] A1  = 19'h200;
    localparam logic [71:0] D00 = 72'h1111;
    localparam logic [71:0] D01 = 72'h2222;
    localparam logic [71:0] D10 = 72'h3333;
    localparam logic [71:0] D11 = 72'h4444;

    logic memclk = 1'b0;
    logic memreset;
    logic cal_done;
    logic tag_overflow;
`ifdef QDR_ARB_STATS_EN
    logic [31:0] wr_grant_cnt, rd_grant_cnt;
`endif
    int checks = 0;
    int failures = 0;

    qdr_port_arbiter_if #(.NUM_REQ(2), .MEM_ADDR_WIDTH(19), .MEM_WIDTH(36), .MEM_BW_WIDTH(4)) bus ();

    qdr_port_arbiter dut (
        .memclk       (memclk),
        .memreset     (memreset),
        .cal_done     (cal_done),
        .bus          (bus),
`ifdef QDR_ARB_STATS_EN
        .wr_grant_cnt (wr_grant_cnt),
        .rd_grant_cnt (rd_grant_cnt),
`endif
        .tag_overflow (tag_overflow)
    );

    always #5 memclk = ~memclk;

    typedef struct {
        logic        cal;
        logic [1:0]  wreq;
        logic        wfull;
        logic [1:0]  gnt;
        logic        adn;
        logic        dn;
        logic [71:0] dw;
        logic [7:0]  bw;
        logic [18:0] addr;
    } wvec_t;

    wvec_t       tbl [23];
    logic [71:0] qv  [4];
    logic [1:0]  ev  [5];
    logic        got;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge memclk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          cal  wreq   full  gnt    adn   dn    dw    bw     addr
        tbl[0]  = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 72'h0, 8'h00, 19'h0};
        tbl[1]  = '{1'b1, 2'b11, 1'b0, 2'b01, 1'b1, 1'b1, 72'h0, 8'h00, 19'h0};
        tbl[2]  = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, D00,   8'h5A, A0};
        tbl[3]  = '{1'b1, 2'b11, 1'b0, 2'b10, 1'b1, 1'b0, D01,   8'hA5, 19'h0};
        tbl[4]  = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, D10,   8'hF0, A1};
        tbl[5]  = '{1'b1, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0, D11,   8'h0F, 19'h0};
        tbl[6]  = '{1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, D00,   8'h5A, A0};
        tbl[7]  = '{1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, D01,   8'hA5, 19'h0};
        tbl[8]  = '{1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 72'h0, 8'h00, 19'h0};
        tbl[9]  = '{1'b1, 2'b11, 1'b0, 2'b10, 1'b1, 1'b1, 72'h0, 8'h00, 19'h0};
        tbl[10] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, D10,   8'hF0, A1};
        tbl[11] = '{1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0, D11,   8'h0F, 19'h0};
        tbl[12] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, D00,   8'h5A, A0};
        tbl[13] = '{1'b1, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0, D01,   8'hA5, 19'h0};
        tbl[14] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, D10,   8'hF0, A1};
        tbl[15] = '{1'b1, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0, D11,   8'h0F, 19'h0};
        tbl[16] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, D10,   8'hF0, A1};
        tbl[17] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, D11,   8'h0F, 19'h0};
        tbl[18] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 72'h0, 8'h00, 19'h0};
        tbl[19] = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b1, 1'b1, 72'h0, 8'h00, 19'h0};
        tbl[20] = '{1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, D00,   8'h5A, A0};
        tbl[21] = '{1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, D01,   8'hA5, 19'h0};
        tbl[22] = '{1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b1, 72'h0, 8'h00, 19'h0};
        qv[0] = 72'hAA01; qv[1] = 72'hAA02; qv[2] = 72'hBB01; qv[3] = 72'hBB02;
        ev[0] = 2'b01; ev[1] = 2'b01; ev[2] = 2'b10; ev[3] = 2'b10; ev[4] = 2'b00;

        memreset = 1'b1;
        cal_done = 1'b0;
        bus.wr_req = '0;
        bus.wr_addr = {A1, A0};
        bus.wr_data = {D11, D10, D01, D00};
        bus.wr_bw_n = {8'h0F, 8'hF0, 8'hA5, 8'h5A};
        bus.rd_req = '0;
        bus.rd_addr = {19'h20, 19'h10};
        bus.user_wr_full = 1'b0;
        bus.user_rd_full = 1'b0;
        bus.user_qr = '0;
        bus.user_qr_valid = 1'b0;
        repeat (3) step();
        memreset = 1'b0;

        @(negedge memclk);
        chk("rst_wr_gnt", bus.wr_gnt, 0);
        chk("rst_rd_gnt", bus.rd_gnt, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_ad_w_n", bus.user_ad_w_n, 1);
        chk("rst_d_w_n", bus.user_d_w_n, 1);
        chk("rst_r_n", bus.user_r_n, 1);
        chk("rst_overflow", tag_overflow, 0);
        step();

        // no grants before calibration
        bus.wr_req = 2'b11;
        bus.rd_req = 2'b11;
        for (int c = 0; c < 50; c++) begin
            @(negedge memclk);
            chk("t1_no_gnt", {bus.wr_gnt, bus.rd_gnt}, 0);
            step();
        end
        bus.rd_req = 2'b00;

        // write channel vectors
        for (int r = 0; r < 23; r++) begin
            cal_done = tbl[r].cal;
            bus.wr_req = tbl[r].wreq;
            bus.user_wr_full = tbl[r].wfull;
            @(negedge memclk);
            chk($sformatf("w%0d_gnt", r), bus.wr_gnt, tbl[r].gnt);
            chk($sformatf("w%0d_ad_w_n", r), bus.user_ad_w_n, tbl[r].adn);
            chk($sformatf("w%0d_d_w_n", r), bus.user_d_w_n, tbl[r].dn);
            if (!tbl[r].dn) begin
                chk($sformatf("w%0d_dw", r), bus.user_dw, tbl[r].dw);
                chk($sformatf("w%0d_bw_n", r), bus.user_bw_n, tbl[r].bw);
            end
            if (!tbl[r].adn) chk($sformatf("w%0d_ad_wr", r), bus.user_ad_wr, tbl[r].addr);
            step();
        end
        bus.user_wr_full = 1'b0;
        bus.wr_req = 2'b00;
        cal_done = 1'b1;
        repeat (2) step();

        // two reads, returns steered by tag
        bus.rd_req = 2'b11;
        @(negedge memclk);
        chk("t3_gnt0", bus.rd_gnt, 2'b01);
        step();
        bus.rd_req = 2'b10;
        @(negedge memclk);
        chk("t3_gnt1", bus.rd_gnt, 2'b10);
        chk("t3_r_n0", bus.user_r_n, 0);
        chk("t3_ad_rd0", bus.user_ad_rd, 19'h10);
        step();
        bus.rd_req = 2'b00;
        @(negedge memclk);
        chk("t3_gnt2", bus.rd_gnt, 2'b00);
        chk("t3_r_n1", bus.user_r_n, 0);
        chk("t3_ad_rd1", bus.user_ad_rd, 19'h20);
        step();
        @(negedge memclk);
        chk("t3_r_n_idle", bus.user_r_n, 1);
        repeat (7) step();
        for (int i = 0; i < 6; i++) begin
            bus.user_qr_valid = (i < 4);
            bus.user_qr = (i < 4) ? qv[i] : 72'h0;
            @(negedge memclk);
            if (i > 0) begin
                chk($sformatf("t3_valid%0d", i - 1), bus.rd_valid, ev[i - 1]);
                if (i < 5) chk($sformatf("t3_data%0d", i - 1), bus.rd_data, qv[i - 1]);
            end
            step();
        end

        // fill the tag FIFO, then free one slot
        bus.rd_req = 2'b01;
        for (int i = 0; i < 16; i++) begin
            @(negedge memclk);
            chk($sformatf("t4_fill%0d", i), bus.rd_gnt, 2'b01);
            step();
        end
        @(negedge memclk);
        chk("t4_blocked_a", bus.rd_gnt, 2'b00);
        step();
        bus.user_qr_valid = 1'b1;
        bus.user_qr = 72'hCC01;
        @(negedge memclk);
        chk("t4_blocked_b", bus.rd_gnt, 2'b00);
        step();
        bus.user_qr = 72'hCC02;
        @(negedge memclk);
        chk("t4_blocked_c", bus.rd_gnt, 2'b00);
        chk("t4_ret_valid0", bus.rd_valid, 2'b01);
        chk("t4_ret_data0", bus.rd_data, 72'hCC01);
        step();
        bus.user_qr_valid = 1'b0;
        @(negedge memclk);
        chk("t4_regrant", bus.rd_gnt, 2'b01);
        chk("t4_ret_valid1", bus.rd_valid, 2'b01);
        step();
        bus.rd_req = 2'b00;
`ifdef QDR_ARB_STATS_EN
        @(negedge memclk);
        chk("stats_wr", wr_grant_cnt, 8);
        chk("stats_rd", rd_grant_cnt, 19);
        step();
`endif

        // spurious return with nothing outstanding
        memreset = 1'b1;
        step();
        memreset = 1'b0;
        @(negedge memclk);
        chk("t5_rst_r_n", bus.user_r_n, 1);
        chk("t5_rst_valid", bus.rd_valid, 0);
        step();
        bus.user_qr_valid = 1'b1;
        bus.user_qr = 72'h5555;
        step();
        bus.user_qr_valid = 1'b0;
        @(negedge memclk);
        chk("t5_valid", bus.rd_valid, 0);
        chk("t5_overflow", tag_overflow, 1);
        repeat (3) step();
        @(negedge memclk);
        chk("t5_overflow_held", tag_overflow, 1);
        step();

        // reset in the middle of a write
        bus.wr_req = 2'b01;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!got) begin
                @(negedge memclk);
                if (bus.wr_gnt == 2'b01) got = 1'b1;
                else step();
            end
        end
        chk("t6_wr_gnt_seen", got, 1);
        step();
        bus.wr_req = 2'b00;
        memreset = 1'b1;
        @(negedge memclk);
        chk("t6_beat0_d_w_n", bus.user_d_w_n, 0);
        step();
        memreset = 1'b0;
        @(negedge memclk);
        chk("t6_d_w_n", bus.user_d_w_n, 1);
        chk("t6_ad_w_n", bus.user_ad_w_n, 1);
        chk("t6_wr_gnt", bus.wr_gnt, 0);
        chk("t6_overflow", tag_overflow, 0);
`ifdef QDR_ARB_STATS_EN
        chk("t6_stats_wr", wr_grant_cnt, 0);
        chk("t6_stats_rd", rd_grant_cnt, 0);
`endif
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
